// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through 4-bit CLA groups,
// with the inter-chunk carry held in a register and word-level P/G accumulated on the way.
module seq_cla_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             p_out,
    output logic             g_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int NG     = CHUNK / 4;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] c;   // carries into bits 0..3 of the group
        logic       gp;
        logic       gg;
    } cla4_t;

    function automatic cla4_t cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
        cla4_t r;
        r.c[0] = c0;
        r.c[1] = g[0] | (p[0] & c0);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        r.gp   = &p;
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

    state_t             state_r, state_next;
    logic               busy_next, done_next;
    logic [WIDTH-1:0]   a_r, b_r, sum_r;
    logic               carry_r, p_acc_r, g_acc_r;
    logic [IDX_W-1:0]   idx_r;
    logic               c_out_r, overflow_r, p_out_r, g_out_r, busy_r, done_r;

    logic               accept_s, last_s;
    logic [CHUNK-1:0]   a_k_s, b_k_s, p_s, g_s, bit_c_s, chunk_sum_s;
    logic [NG:0]        gc_s;
    logic               chunk_p_s, chunk_g_s, chunk_cout_s, msb_cin_s;
    cla4_t              grp_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (idx_r == IDX_W'(NCHUNK - 1));

    // State register plus registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            busy_r  <= busy_next;
            done_r  <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    state_next = start  ? RUN : IDLE;
            RUN:     state_next = last_s ? DONE : RUN;
            DONE:    state_next = start  ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode, registered by the state-register block
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            RUN:     busy_next = 1'b1;
            DONE:    done_next = 1'b1;
            default: begin
                busy_next = 1'b0;
                done_next = 1'b0;
            end
        endcase
    end

    // Chunk datapath: CLA groups inside the slice, look-ahead between groups
    always_comb begin
        a_k_s     = a_r[idx_r*CHUNK +: CHUNK];
        b_k_s     = b_r[idx_r*CHUNK +: CHUNK];
        p_s       = a_k_s ^ b_k_s;
        g_s       = a_k_s & b_k_s;
        gc_s      = '0;
        gc_s[0]   = carry_r;
        bit_c_s   = '0;
        chunk_p_s = 1'b1;
        chunk_g_s = 1'b0;
        grp_s     = '0;
        for (int j = 0; j < NG; j++) begin
            grp_s             = cla4(p_s[4*j +: 4], g_s[4*j +: 4], gc_s[j]);
            bit_c_s[4*j +: 4] = grp_s.c;
            gc_s[j+1]         = grp_s.gg | (grp_s.gp & gc_s[j]);
            chunk_g_s         = grp_s.gg | (grp_s.gp & chunk_g_s);
            chunk_p_s         = chunk_p_s & grp_s.gp;
        end
        chunk_sum_s  = p_s ^ bit_c_s;
        chunk_cout_s = gc_s[NG];
        msb_cin_s    = bit_c_s[CHUNK-1];
    end

    // Operand latch, per-chunk update and final flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            sum_r      <= '0;
            carry_r    <= 1'b0;
            p_acc_r    <= 1'b0;
            g_acc_r    <= 1'b0;
            idx_r      <= '0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
            p_out_r    <= 1'b0;
            g_out_r    <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= mode ? ~b : b;
            carry_r <= mode ? 1'b1 : c_in;
            idx_r   <= '0;
            p_acc_r <= 1'b1;
            g_acc_r <= 1'b0;
            sum_r   <= '0;
        end else if (state_r == RUN) begin
            sum_r[idx_r*CHUNK +: CHUNK] <= chunk_sum_s;
            carry_r <= chunk_cout_s;
            p_acc_r <= p_acc_r & chunk_p_s;
            g_acc_r <= chunk_g_s | (chunk_p_s & g_acc_r);
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
                c_out_r    <= chunk_cout_s;
                overflow_r <= msb_cin_s ^ chunk_cout_s;
                p_out_r    <= p_acc_r & chunk_p_s;
                g_out_r    <= chunk_g_s | (chunk_p_s & g_acc_r);
            end else begin
                c_out_r    <= c_out_r;
                overflow_r <= overflow_r;
                p_out_r    <= p_out_r;
                g_out_r    <= g_out_r;
            end
        end else begin
            sum_r <= sum_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;
    assign p_out    = p_out_r;
    assign g_out    = g_out_r;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed bench for seq_cla_adder (WIDTH=16, CHUNK=4): vector table plus corner sequences.
module tb_seq_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        c_in = 1'b0;
    logic        busy, done, c_out, overflow, p_out, g_out;
    logic [15:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_cla_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow),
        .p_out(p_out), .g_out(g_out)
    );

    typedef struct {
        logic        m;
        logic [15:0] av;
        logic [15:0] bv;
        logic        ci;
        logic [15:0] e_sum;
        logic        e_c;
        logic        e_ovf;
        logic        e_p;
        logic        e_g;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts cycles after the accepting edge until done, checking busy on the way
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            chk("busy_in_run", {31'd0, busy}, 32'd1);
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic launch(input logic m, input logic [15:0] av, input logic [15:0] bv, input logic ci);
        @(negedge clk);
        mode = m; a = av; b = bv; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, "_sum"},  {16'd0, sum},         {16'd0, v.e_sum});
        chk({tag, "_cout"}, {31'd0, c_out},       {31'd0, v.e_c});
        chk({tag, "_ovf"},  {31'd0, overflow},    {31'd0, v.e_ovf});
        chk({tag, "_p"},    {31'd0, p_out},       {31'd0, v.e_p});
        chk({tag, "_g"},    {31'd0, g_out},       {31'd0, v.e_g});
        chk({tag, "_busy"}, {31'd0, busy},        32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {16'd0, sum},  32'd0);
        chk("rst_flags", {28'd0, c_out, overflow, p_out, g_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].m, vecs[i].av, vecs[i].bv, vecs[i].ci);
            wait_done(0, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd4);
            check_result(vecs[i], $sformatf("v%0d", i));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_hold_sum", i), {16'd0, sum}, {16'd0, vecs[i].e_sum});
        end

        // Start pulsed during RUN with other operands is ignored
        launch(1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        mode = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, lat);
        chk("ign_latency", lat, 32'd4);
        check_result(vecs[0], "ign");

        // Start held high in DONE: back-to-back acceptance
        launch(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(0, lat);
        check_result(vecs[3], "b2b_first");
        mode = 1'b1; a = 16'h0003; b = 16'h0005; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_drop", {31'd0, done}, 32'd0);
        chk("b2b_sum_clear", {16'd0, sum}, 32'd0);
        wait_done(0, lat);
        chk("b2b_latency", lat, 32'd4);
        check_result(vecs[6], "b2b_second");

        // Reset mid-RUN after two chunks
        launch(1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_partial_sum", {16'd0, sum}, 32'h0055);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_sum",  {16'd0, sum},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("mid_no_done", {31'd0, seen}, 32'd0);
        launch(vecs[1].m, vecs[1].av, vecs[1].bv, vecs[1].ci);
        wait_done(0, lat);
        chk("mid_fresh_latency", lat, 32'd4);
        check_result(vecs[1], "mid_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_cla_adder.md
Name: seq_cla_adder

Overview:
- Parametrised multi-cycle adder/subtractor built from 4-bit carry-look-ahead groups.
- Processes one CHUNK-bit slice of the operands per clock, LSB slice first, and registers the inter-chunk carry.
- Accumulates word-level group propagate/generate, and reports carry-out and signed overflow.
- Sits behind the combinational CLA unit in the datapath; trades latency for area at wide WIDTH.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; must be a multiple of 4 (CHUNK/4 CLA groups per cycle, look-ahead across groups).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  1  0 = add, 1 = subtract (a - b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in, add mode only.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- p_out  output  1  word group propagate = AND of all bit propagates.
- g_out  output  1  word group generate (equals c_out when the effective carry-in is 0).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, sum, c_out, overflow, p_out and g_out all 0; internal registers cleared. Reset mid-RUN aborts the operation with no partial result kept.
- States are IDLE, RUN and DONE. NCHUNK = WIDTH/CHUNK.
- Start acceptance (edge E0, start=1 in IDLE or DONE):
  - latch a and b' = mode ? ~b : b;
  - carry register = mode ? 1 : c_in (c_in ignored when mode=1);
  - idx = 0; P_acc = 1; G_acc = 0; state goes to RUN; busy=1; done=0; sum cleared to 0.
- RUN, edges E1..E_NCHUNK, one chunk per edge:
  - slice k = idx: p = a_k ^ b'_k, g = a_k & b'_k; CLA groups produce the chunk sum and carries.
  - sum[k*CHUNK +: CHUNK] is written.
  - carry register = chunk carry-out.
  - P_acc = P_acc & chunk_P; G_acc = chunk_G | (chunk_P & G_acc).
  - idx increments.
- Leaving RUN: at E_NCHUNK (idx = NCHUNK-1) state goes to DONE.
  - c_out = final carry; overflow = carry into bit WIDTH-1 XOR c_out.
  - p_out = P_acc; g_out = G_acc. busy=0; done=1.
- Latency: done is high exactly NCHUNK cycles after the accepting edge, for exactly one cycle.
- DONE: the next edge returns to IDLE, or to RUN if start=1 (back-to-back; done drops, busy rises).
- Results hold in IDLE until the next accepted start.
- start=1 while busy is ignored; no effect on the operation in flight. Operands, mode and c_in are don't-care after E0.
- Carry ripples between chunks only through the carry register. Wrap-around is modulo 2^WIDTH, with the carry reported on c_out.
- CHUNK == WIDTH is legal: single RUN cycle, done at E1.

Test Plan (WIDTH=16, CHUNK=4):
- Reset, then add a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0, overflow=0; done pulses one cycle, 4 cycles after start; busy high for cycles 1-4 only.
- Add a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0, p_out=0, g_out=1.
- Add a=0x000F, b=0x0000, c_in=1 -> sum=0x0010, c_out=0 (carry crosses the chunk boundary via register). Add a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1, c_out=0.
- Subtract a=0x8000, b=0x0001, c_in=1 and then c_in=0 -> both give sum=0x7FFF, c_out=1, overflow=1. Subtract 0x0003-0x0005 -> sum=0xFFFE, c_out=0.
- Start pulsed during RUN with different operands -> ignored, first result unchanged. Start held high in DONE -> second op accepted, done pulses again 4 cycles later.
- rst_n low mid-RUN (after 2 chunks) -> busy, done and sum immediately 0. After release, no done until a new start; a fresh add completes correctly.
